// File: rtl/acc_offload_tracker.sv
// acc_offload_tracker
//   Tracks accelerator offload requests from a core. Each accepted request is
//   given the lowest free id, its destination register tag is remembered, and
//   the payload is presented through a one-entry output register. Responses
//   carry the id back; the tag is looked up combinationally and the id freed
//   when the core takes the response.
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   core_q_*  (valid/ready/addr/arga/argb/argc/op/rd)   core request in
//   acc_q_*   (valid/ready/addr/arga/argb/argc/op/id)   registered request out
//   acc_p_*   (valid/ready/id/data)                     interconnect response in
//   core_p_*  (valid/ready/data/rd)                     response to core
//   outstanding_o                     number of allocated ids
//   err_o                             sticky protocol error
//
// Optional feature macro: ACC_OFFLOAD_TRACKER_ERR_CHECK_EN
//   Defined: responses to unallocated ids are swallowed and flag err_o.
//   Undefined: such responses pass through untouched, err_o is tied 0.

package acc_pkg;
  localparam int AccAddrWidth = 32;
endpackage

module acc_offload_tracker #(
  parameter int NumIds       = 32,
  parameter int AccAddrWidth = acc_pkg::AccAddrWidth,
  parameter int DataWidth    = 32,
  localparam int CntW        = $clog2(NumIds + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    core_q_valid_i,
  output logic                    core_q_ready_o,
  input  logic [AccAddrWidth-1:0] core_q_addr_i,
  input  logic [DataWidth-1:0]    core_q_arga_i,
  input  logic [DataWidth-1:0]    core_q_argb_i,
  input  logic [DataWidth-1:0]    core_q_argc_i,
  input  logic [31:0]             core_q_op_i,
  input  logic [4:0]              core_q_rd_i,
  output logic                    acc_q_valid_o,
  input  logic                    acc_q_ready_i,
  output logic [AccAddrWidth-1:0] acc_q_addr_o,
  output logic [DataWidth-1:0]    acc_q_arga_o,
  output logic [DataWidth-1:0]    acc_q_argb_o,
  output logic [DataWidth-1:0]    acc_q_argc_o,
  output logic [31:0]             acc_q_op_o,
  output logic [4:0]              acc_q_id_o,
  input  logic                    acc_p_valid_i,
  output logic                    acc_p_ready_o,
  input  logic [4:0]              acc_p_id_i,
  input  logic [DataWidth-1:0]    acc_p_data_i,
  output logic                    core_p_valid_o,
  input  logic                    core_p_ready_i,
  output logic [DataWidth-1:0]    core_p_data_o,
  output logic [4:0]              core_p_rd_o,
  output logic [CntW-1:0]         outstanding_o,
  output logic                    err_o
);

  localparam int IdxW = (NumIds > 1) ? $clog2(NumIds) : 1;

  logic [NumIds-1:0]       r_free;
  logic [4:0]              r_rd_tbl [NumIds];
  logic                    r_q_valid;
  logic [AccAddrWidth-1:0] r_q_addr;
  logic [DataWidth-1:0]    r_q_arga, r_q_argb, r_q_argc;
  logic [31:0]             r_q_op;
  logic [4:0]              r_q_id;
  logic [CntW-1:0]         r_cnt;

  logic              w_any_free;
  logic [IdxW-1:0]   w_alloc_idx;
  logic              w_accept;
  logic [IdxW-1:0]   w_rsp_idx;
  logic              w_rsp_in_range;
  logic              w_rsp_hit;
  logic              w_free;
  logic [NumIds-1:0] w_alloc_mask;
  logic [NumIds-1:0] w_free_mask;

  // Lowest-index free id; scanning downward lets the lowest set bit win.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (r_free[i]) w_alloc_idx = IdxW'(i);
    end
  end

  assign w_any_free     = |r_free;
  // Ready is gated by reset so nothing looks acceptable while held in reset.
  assign core_q_ready_o = !rst_i && w_any_free && (!r_q_valid || acc_q_ready_i);
  assign w_accept       = core_q_valid_i && core_q_ready_o;

  // Ids beyond NumIds never index the tables; they count as unallocated.
  assign w_rsp_idx      = acc_p_id_i[IdxW-1:0];
  assign w_rsp_in_range = ({1'b0, acc_p_id_i} < 6'(NumIds));
  assign w_rsp_hit      = w_rsp_in_range && !r_free[w_rsp_idx];

  assign core_p_data_o  = acc_p_data_i;
  assign core_p_rd_o    = w_rsp_in_range ? r_rd_tbl[w_rsp_idx] : 5'd0;

`ifdef ACC_OFFLOAD_TRACKER_ERR_CHECK_EN
  logic r_err;

  assign core_p_valid_o = acc_p_valid_i && w_rsp_hit;
  // Stray responses are drained locally so the interconnect never stalls on them.
  assign acc_p_ready_o  = w_rsp_hit ? core_p_ready_i : 1'b1;
  assign err_o          = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            r_err <= 1'b0;
    else if (acc_p_valid_i && !w_rsp_hit) r_err <= 1'b1;
  end
`else
  assign core_p_valid_o = acc_p_valid_i;
  assign acc_p_ready_o  = core_p_ready_i;
  assign err_o          = 1'b0;
`endif

  // A stray response may still handshake; only a real allocation is released.
  assign w_free       = core_p_valid_o && core_p_ready_i && w_rsp_hit;
  assign w_alloc_mask = w_accept ? (NumIds'(1) << w_alloc_idx) : '0;
  assign w_free_mask  = w_free   ? (NumIds'(1) << w_rsp_idx)   : '0;

  // Allocation only picks ids free in the registered map and a free only hits
  // an allocated id, so the two masks never overlap. A freed id becomes
  // visible to the allocator on the following cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_free <= '1;
      r_cnt  <= '0;
    end else begin
      r_free <= (r_free & ~w_alloc_mask) | w_free_mask;
      case ({w_accept, w_free})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) r_rd_tbl[w_alloc_idx] <= core_q_rd_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q_valid <= 1'b0;
      r_q_addr  <= '0;
      r_q_arga  <= '0;
      r_q_argb  <= '0;
      r_q_argc  <= '0;
      r_q_op    <= '0;
      r_q_id    <= '0;
    end else if (w_accept) begin
      r_q_valid <= 1'b1;
      r_q_addr  <= core_q_addr_i;
      r_q_arga  <= core_q_arga_i;
      r_q_argb  <= core_q_argb_i;
      r_q_argc  <= core_q_argc_i;
      r_q_op    <= core_q_op_i;
      r_q_id    <= 5'(w_alloc_idx);
    end else if (acc_q_ready_i) begin
      r_q_valid <= 1'b0;
    end
  end

  assign acc_q_valid_o = r_q_valid;
  assign acc_q_addr_o  = r_q_addr;
  assign acc_q_arga_o  = r_q_arga;
  assign acc_q_argb_o  = r_q_argb;
  assign acc_q_argc_o  = r_q_argc;
  assign acc_q_op_o    = r_q_op;
  assign acc_q_id_o    = r_q_id;
  assign outstanding_o = r_cnt;

endmodule

// File: tb/tb_acc_offload_tracker.sv
module tb_acc_offload_tracker;

  localparam int NIDS = 4;
  localparam int CW   = $clog2(NIDS + 1);
`ifdef ACC_OFFLOAD_TRACKER_ERR_CHECK_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_q_valid_i, core_q_ready_o;
  logic [31:0] core_q_addr_i, core_q_arga_i, core_q_argb_i, core_q_argc_i, core_q_op_i;
  logic [4:0]  core_q_rd_i;
  logic        acc_q_valid_o, acc_q_ready_i;
  logic [31:0] acc_q_addr_o, acc_q_arga_o, acc_q_argb_o, acc_q_argc_o, acc_q_op_o;
  logic [4:0]  acc_q_id_o;
  logic        acc_p_valid_i, acc_p_ready_o;
  logic [4:0]  acc_p_id_i;
  logic [31:0] acc_p_data_i;
  logic        core_p_valid_o, core_p_ready_i;
  logic [31:0] core_p_data_o;
  logic [4:0]  core_p_rd_o;
  logic [CW-1:0] outstanding_o;
  logic        err_o;

  acc_offload_tracker #(.NumIds(NIDS), .AccAddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_q_valid_i(core_q_valid_i), .core_q_ready_o(core_q_ready_o),
    .core_q_addr_i(core_q_addr_i), .core_q_arga_i(core_q_arga_i),
    .core_q_argb_i(core_q_argb_i), .core_q_argc_i(core_q_argc_i),
    .core_q_op_i(core_q_op_i), .core_q_rd_i(core_q_rd_i),
    .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
    .acc_q_addr_o(acc_q_addr_o), .acc_q_arga_o(acc_q_arga_o),
    .acc_q_argb_o(acc_q_argb_o), .acc_q_argc_o(acc_q_argc_o),
    .acc_q_op_o(acc_q_op_o), .acc_q_id_o(acc_q_id_o),
    .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
    .acc_p_id_i(acc_p_id_i), .acc_p_data_i(acc_p_data_i),
    .core_p_valid_o(core_p_valid_o), .core_p_ready_i(core_p_ready_i),
    .core_p_data_o(core_p_data_o), .core_p_rd_o(core_p_rd_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        qv;  logic [4:0] rd;  logic [31:0] op;  logic ar;
    logic        pv;  logic [4:0] pid; logic [31:0] pd;  logic pr;
    logic        chk_q; logic e_qr; logic e_av; logic [4:0] e_aid; logic [31:0] e_aop;
    logic [CW-1:0] e_out;
    logic        chk_p; logic e_cpv; logic [4:0] e_crd; logic e_apr; logic e_err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    logic qv, logic [4:0] rd, logic [31:0] op, logic ar,
    logic pv, logic [4:0] pid, logic [31:0] pd, logic pr,
    logic chk_q, logic e_qr, logic e_av, logic [4:0] e_aid, logic [31:0] e_aop,
    logic [CW-1:0] e_out,
    logic chk_p, logic e_cpv, logic [4:0] e_crd, logic e_apr, logic e_err);
    vec_t v;
    v.qv = qv; v.rd = rd; v.op = op; v.ar = ar;
    v.pv = pv; v.pid = pid; v.pd = pd; v.pr = pr;
    v.chk_q = chk_q; v.e_qr = e_qr; v.e_av = e_av; v.e_aid = e_aid; v.e_aop = e_aop;
    v.e_out = e_out;
    v.chk_p = chk_p; v.e_cpv = e_cpv; v.e_crd = e_crd; v.e_apr = e_apr; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    core_q_valid_i = v.qv; core_q_rd_i = v.rd; core_q_op_i = v.op;
    core_q_addr_i = v.op ^ 32'hA000_0000; core_q_arga_i = v.op + 1;
    core_q_argb_i = v.op + 2; core_q_argc_i = v.op + 3;
    acc_q_ready_i = v.ar;
    acc_p_valid_i = v.pv; acc_p_id_i = v.pid; acc_p_data_i = v.pd;
    core_p_ready_i = v.pr;
  endtask

  initial begin
    // qv rd op ar | pv pid pd pr | chk_q qr av aid aop out | chk_p cpv crd apr err
    vecs.push_back(mk(1,7,32'h33,1, 0,0,0,1,           0,1,0,0,0,0,    0,0,0,1,0));
    vecs.push_back(mk(1,3,32'h41,1, 0,0,0,1,           1,1,1,0,32'h33,1, 0,0,0,1,0));
    vecs.push_back(mk(1,5,32'h42,1, 0,0,0,1,           1,1,1,1,32'h41,2, 0,0,0,1,0));
    vecs.push_back(mk(1,9,32'h43,1, 0,0,0,1,           1,1,1,2,32'h42,3, 0,0,0,1,0));
    vecs.push_back(mk(1,1,32'h44,1, 0,0,0,1,           1,0,1,3,32'h43,4, 0,0,0,1,0));
    vecs.push_back(mk(1,1,32'h44,1, 1,2,32'hDEAD,1,    0,0,0,0,0,4,    1,1,5,1,0));
    vecs.push_back(mk(1,1,32'h44,1, 0,0,0,1,           0,1,0,0,0,3,    0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,      1,0,32'h1111,1,    1,0,1,2,32'h44,4, 1,1,7,1,0));
    vecs.push_back(mk(1,4,32'h55,0, 0,0,0,1,           1,0,1,2,32'h44,3, 0,0,0,1,0));
    vecs.push_back(mk(1,4,32'h55,0, 0,0,0,1,           1,0,1,2,32'h44,3, 0,0,0,1,0));
    vecs.push_back(mk(1,4,32'h55,1, 1,1,32'h2222,1,    1,1,1,2,32'h44,3, 1,1,3,1,0));
    vecs.push_back(mk(0,0,0,1,      1,3,32'h3333,0,    1,1,1,0,32'h55,3, 1,1,9,0,0));
    vecs.push_back(mk(0,0,0,1,      0,0,0,1,           0,1,0,0,0,3,    0,0,0,1,0));
    vecs.push_back(mk(0,0,0,1,      1,1,32'h4444,0,    0,1,0,0,0,3,    0,!E,0,E,0));
    vecs.push_back(mk(0,0,0,1,      1,9,32'h5555,1,    0,1,0,0,0,3,    0,!E,0,1,E));
    vecs.push_back(mk(0,0,0,1,      0,0,0,1,           0,1,0,0,0,3,    0,0,0,1,E));

    rst_i = 1'b1;
    drive(mk(0,0,0,0, 0,0,0,1, 0,0,0,0,0,0, 0,0,0,0,0));
    repeat (2) @(negedge clk_i);
    core_q_valid_i = 1'b1;
    #1;
    chk("rst_qready", core_q_ready_o, 0);
    chk("rst_avalid", acc_q_valid_o, 0);
    chk("rst_out",    outstanding_o, 0);
    chk("rst_err",    err_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_qready", i), core_q_ready_o, vecs[i].e_qr);
      chk($sformatf("v%0d_avalid", i), acc_q_valid_o, vecs[i].e_av);
      chk($sformatf("v%0d_out", i),    outstanding_o, vecs[i].e_out);
      chk($sformatf("v%0d_cpvalid", i), core_p_valid_o, vecs[i].e_cpv);
      chk($sformatf("v%0d_apready", i), acc_p_ready_o, vecs[i].e_apr);
      chk($sformatf("v%0d_err", i),    err_o, vecs[i].e_err);
      if (vecs[i].chk_q) begin
        chk($sformatf("v%0d_aid", i), acc_q_id_o, vecs[i].e_aid);
        chk($sformatf("v%0d_aop", i), acc_q_op_o, vecs[i].e_aop);
        chk($sformatf("v%0d_aaddr", i), acc_q_addr_o, vecs[i].e_aop ^ 32'hA000_0000);
        chk($sformatf("v%0d_aargc", i), acc_q_argc_o, vecs[i].e_aop + 3);
      end
      if (vecs[i].chk_p) begin
        chk($sformatf("v%0d_crd", i),   core_p_rd_o, vecs[i].e_crd);
        chk($sformatf("v%0d_cdata", i), core_p_data_o, vecs[i].pd);
      end
      @(negedge clk_i);
    end

    // Allocate and free in the same cycle while the output stays blocked,
    // then hit reset mid-flight.
    drive(mk(1,6,32'h77,0, 1,2,32'h5555,1, 0,0,0,0,0,0, 0,0,0,0,0));
    #1;
    chk("mid_qready", core_q_ready_o, 1);
    chk("mid_crd",    core_p_rd_o, 1);
    @(negedge clk_i);
    acc_p_valid_i = 1'b0;
    #1;
    chk("mid_avalid", acc_q_valid_o, 1);
    chk("mid_aid",    acc_q_id_o, 1);
    chk("mid_aop",    acc_q_op_o, 32'h77);
    chk("mid_out",    outstanding_o, 3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_avalid", acc_q_valid_o, 0);
    chk("arst_out",    outstanding_o, 0);
    chk("arst_qready", core_q_ready_o, 0);
    chk("arst_err",    err_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(mk(1,2,32'h66,1, 0,0,0,1, 0,0,0,0,0,0, 0,0,0,0,0));
    #1;
    chk("post_qready", core_q_ready_o, 1);
    @(negedge clk_i);
    core_q_valid_i = 1'b0;
    acc_p_valid_i = 1'b1; acc_p_id_i = 5'd9; core_p_ready_i = 1'b0;
    #1;
    chk("post_avalid", acc_q_valid_o, 1);
    chk("post_aid",    acc_q_id_o, 0);
    chk("post_aop",    acc_q_op_o, 32'h66);
    chk("post_out",    outstanding_o, 1);
    chk("stray_apready", acc_p_ready_o, E);
    chk("stray_cpvalid", core_p_valid_o, !E);
    @(negedge clk_i);
    acc_p_valid_i = 1'b0; core_p_ready_i = 1'b1;
    #1;
    chk("stray_err1", err_o, E);
    chk("stray_out",  outstanding_o, 1);
    repeat (2) @(negedge clk_i);
    #1;
    chk("stray_err_sticky", err_o, E);
    rst_i = 1'b1;
    #1;
    chk("stray_err_clr", err_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
